fault_confinement: RTL and testbench

//  Downstream of the bit monitor and the other error detectors. Keeps the

---
 rtl/can_fc_pkg.sv | 21 ++
 rtl/boff_rcvry_cnt.sv | 44 ++++
 rtl/fault_confinement.sv | 135 +++++++++++++
 tb/tb_fault_confinement.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_fc_pkg.sv
// Shared types and constants for the CAN fault-confinement block.
package can_fc_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'b00,
    ST_PASSIVE = 2'b01,
    ST_BUSOFF  = 2'b10
  } err_state_t;

  localparam int TEC_INC_TX  = 8;
  localparam int REC_INC_RX  = 1;
  localparam int REC_INC_DOM = 8;
  localparam int REC_RELOAD  = 120;

  localparam int WARN_LIM   = 96;
  localparam int PSV_LIM    = 128;
  localparam int BOFF_LIM   = 256;
  localparam int RCVRY_SEQ  = 128;
  localparam int RCVRY_BITS = 11;

endpackage

// File: rtl/boff_rcvry_cnt.sv
// Bus-off recovery: counts runs of RCVRY_BITS recessive samples and flags the
// sample that completes the RCVRY_SEQ-th run.
module boff_rcvry_cnt
  import can_fc_pkg::*;
#(
  parameter int SEQ_NUM  = RCVRY_SEQ,
  parameter int SEQ_BITS = RCVRY_BITS
) (
  input  logic clk,
  input  logic g_rst,
  input  logic en,
  input  logic smp_pls,
  input  logic sampled_bit,
  output logic seq_done
);

  logic [3:0] bit_cnt;
  logic [7:0] seq_cnt;
  logic       seq_end;

  assign seq_end  = en && smp_pls && sampled_bit && (bit_cnt == 4'(SEQ_BITS - 1));
  assign seq_done = seq_end && (seq_cnt == 8'(SEQ_NUM - 1));

  // A dominant sample restarts only the current run; completed runs are kept.
  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      bit_cnt <= '0;
      seq_cnt <= '0;
    end else if (!en || seq_done) begin
      bit_cnt <= '0;
      seq_cnt <= '0;
    end else if (smp_pls) begin
      if (!sampled_bit) begin
        bit_cnt <= '0;
      end else if (seq_end) begin
        bit_cnt <= '0;
        seq_cnt <= seq_cnt + 8'd1;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/fault_confinement.sv
// TEC/REC error counters, error-active/passive/bus-off state and bus-off
// recovery for a CAN node.
module fault_confinement
  import can_fc_pkg::*;
#(
  parameter int WARN_LIM_P = WARN_LIM,
  parameter int PSV_LIM_P  = PSV_LIM,
  parameter int BOFF_LIM_P = BOFF_LIM
) (
  input  logic       clk,
  input  logic       g_rst,
  input  logic       smp_pls,
  input  logic       sampled_bit,
  input  logic       tx_role,
  input  logic       bt_err,
  input  logic       stf_err,
  input  logic       crc_err,
  input  logic       frm_err,
  input  logic       ack_err,
  input  logic       dom_aft_flg,
  input  logic       tx_success,
  input  logic       rx_success,
  output logic [8:0] tec,
  output logic [7:0] rec,
  output logic [1:0] err_state,
  output logic       err_warn,
  output logic       psv_err_flg,
  output logic       bus_off,
  output logic       rcvry_done
);

  err_state_t st_q, st_nxt;
  logic [8:0] tec_nxt;
  logic [7:0] rec_nxt;
  logic [9:0] tec_sum, rec_sum, rec_inc;
  logic       err_any, err_any_d, err_rise, ack_only_psv, in_boff;
  logic       warn_nxt, seq_done;

  assign err_any      = bt_err | stf_err | crc_err | frm_err | ack_err;
  assign err_rise     = err_any & ~err_any_d;
  assign in_boff      = (st_q == ST_BUSOFF);
  assign ack_only_psv = ack_err & ~(bt_err | stf_err | crc_err | frm_err) &
                        (st_q == ST_PASSIVE);

  boff_rcvry_cnt u_rcvry (
    .clk         (clk),
    .g_rst       (g_rst),
    .en          (bus_off),
    .smp_pls     (smp_pls),
    .sampled_bit (sampled_bit),
    .seq_done    (seq_done)
  );

  // A rising error edge swallows any success pulse of the same clk.
  always_comb begin
    tec_nxt = tec;
    rec_nxt = rec;
    tec_sum = {1'b0, tec} + 10'(TEC_INC_TX);
    rec_inc = '0;
    if (!tx_role) begin
      if (err_rise)    rec_inc = rec_inc + 10'(REC_INC_RX);
      if (dom_aft_flg) rec_inc = rec_inc + 10'(REC_INC_DOM);
    end
    rec_sum = {2'b00, rec} + rec_inc;
    if (seq_done) begin
      tec_nxt = '0;
      rec_nxt = '0;
    end else if (!in_boff) begin
      if (err_rise && tx_role && !ack_only_psv)
        tec_nxt = (tec_sum >= 10'(BOFF_LIM_P)) ? 9'(BOFF_LIM_P) : tec_sum[8:0];
      else if (!err_rise && tx_success && tec != 9'd0)
        tec_nxt = tec - 9'd1;

      if (rec_inc != 10'd0)
        rec_nxt = (rec_sum > 10'd255) ? 8'hFF : rec_sum[7:0];
      else if (!err_rise && rx_success) begin
        if (rec > 8'd127)     rec_nxt = 8'(REC_RELOAD);
        else if (rec != 8'd0) rec_nxt = rec - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      tec       <= '0;
      rec       <= '0;
      err_any_d <= 1'b0;
    end else begin
      tec       <= tec_nxt;
      rec       <= rec_nxt;
      err_any_d <= err_any;
    end
  end

  always_comb begin
    st_nxt = st_q;
    if (seq_done) begin
      st_nxt = ST_ACTIVE;
    end else begin
      case (st_q)
        ST_BUSOFF: st_nxt = ST_BUSOFF;
        default: begin
          if (tec >= 9'(BOFF_LIM_P))
            st_nxt = ST_BUSOFF;
          else if (tec >= 9'(PSV_LIM_P) || rec >= 8'(PSV_LIM_P))
            st_nxt = ST_PASSIVE;
          else
            st_nxt = ST_ACTIVE;
        end
      endcase
    end
    // Counters are still at their bus-off values in the recovery clk.
    warn_nxt = !seq_done && (st_nxt != ST_BUSOFF) &&
               (tec >= 9'(WARN_LIM_P) || rec >= 8'(WARN_LIM_P));
  end

  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      st_q        <= ST_ACTIVE;
      err_warn    <= 1'b0;
      psv_err_flg <= 1'b0;
      bus_off     <= 1'b0;
      rcvry_done  <= 1'b0;
    end else begin
      st_q        <= st_nxt;
      err_warn    <= warn_nxt;
      psv_err_flg <= (st_nxt == ST_PASSIVE);
      bus_off     <= (st_nxt == ST_BUSOFF);
      rcvry_done  <= seq_done;
    end
  end

  assign err_state = st_q;

endmodule

// File: tb/tb_fault_confinement.sv
// Scoreboard bench for fault_confinement: expectations are queued from a small
// behavioural model as stimulus is applied, then drained against the outputs.
module tb_fault_confinement;

  logic       clk = 1'b0, g_rst = 1'b1;
  logic       smp_pls = 1'b0, sampled_bit = 1'b1, tx_role = 1'b0;
  logic       bt_err = 1'b0, stf_err = 1'b0, crc_err = 1'b0, frm_err = 1'b0, ack_err = 1'b0;
  logic       dom_aft_flg = 1'b0, tx_success = 1'b0, rx_success = 1'b0;
  logic [8:0] tec;
  logic [7:0] rec;
  logic [1:0] err_state;
  logic       err_warn, psv_err_flg, bus_off, rcvry_done;

  fault_confinement dut (
    .clk(clk), .g_rst(g_rst), .smp_pls(smp_pls), .sampled_bit(sampled_bit),
    .tx_role(tx_role), .bt_err(bt_err), .stf_err(stf_err), .crc_err(crc_err),
    .frm_err(frm_err), .ack_err(ack_err), .dom_aft_flg(dom_aft_flg),
    .tx_success(tx_success), .rx_success(rx_success), .tec(tec), .rec(rec),
    .err_state(err_state), .err_warn(err_warn), .psv_err_flg(psv_err_flg),
    .bus_off(bus_off), .rcvry_done(rcvry_done)
  );

  always #5 clk = ~clk;

  localparam int SEL_TEC = 0, SEL_REC = 1, SEL_ST = 2, SEL_WARN = 3,
                 SEL_PSV = 4, SEL_BOFF = 5, SEL_RCV = 6;

  typedef struct {
    string tag;
    int    sel;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0, n_rcvry = 0;
  int   m_tec = 0, m_rec = 0;
  bit   m_boff = 1'b0;

  always @(negedge clk) if (rcvry_done === 1'b1) n_rcvry++;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dut_val(input int sel);
    case (sel)
      SEL_TEC:  return int'(tec);
      SEL_REC:  return int'(rec);
      SEL_ST:   return int'(err_state);
      SEL_WARN: return int'(err_warn);
      SEL_PSV:  return int'(psv_err_flg);
      SEL_BOFF: return int'(bus_off);
      default:  return int'(rcvry_done);
    endcase
  endfunction

  task automatic sb_push(input string tag, input int sel, input int exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic sb_drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, dut_val(e.sel), e.exp);
    end
  endtask

  function automatic int model_st();
    if (m_boff) return 2;
    if (m_tec >= 128 || m_rec >= 128) return 1;
    return 0;
  endfunction

  task automatic push_model(input string tag);
    int st;
    st = model_st();
    sb_push({tag, "/tec"}, SEL_TEC, m_tec);
    sb_push({tag, "/rec"}, SEL_REC, m_rec);
    sb_push({tag, "/state"}, SEL_ST, st);
    sb_push({tag, "/warn"}, SEL_WARN, (!m_boff && (m_tec >= 96 || m_rec >= 96)) ? 1 : 0);
    sb_push({tag, "/psv"}, SEL_PSV, (st == 1) ? 1 : 0);
    sb_push({tag, "/boff"}, SEL_BOFF, (st == 2) ? 1 : 0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_err(input int kind, input logic v);
    case (kind)
      0: bt_err  = v;
      1: stf_err = v;
      2: crc_err = v;
      3: frm_err = v;
      default: ack_err = v;
    endcase
  endtask

  task automatic err_ep(input int kind, input int len);
    set_err(kind, 1'b1);
    tick(len);
    set_err(kind, 1'b0);
    tick(2);
  endtask

  task automatic tx_ok();
    tx_success = 1'b1; tick(1); tx_success = 1'b0; tick(2);
  endtask

  task automatic rx_ok();
    rx_success = 1'b1; tick(1); rx_success = 1'b0; tick(2);
  endtask

  task automatic send_bit(input logic b);
    smp_pls = 1'b1; sampled_bit = b; tick(1);
    smp_pls = 1'b0; sampled_bit = 1'b1; tick(1);
  endtask

  task automatic do_reset();
    g_rst = 1'b1; tick(1); g_rst = 1'b0; tick(1);
    m_tec = 0; m_rec = 0; m_boff = 1'b0;
  endtask

  task automatic to_bus_off();
    tx_role = 1'b1;
    for (int i = 0; i < 32; i++) err_ep(0, 1);
    m_tec = 256; m_boff = 1'b1;
  endtask

  initial begin
    tick(2);
    push_model("reset");
    sb_push("reset/rcvry", SEL_RCV, 0);
    sb_drain();
    g_rst = 1'b0;
    tick(1);

    // Fifteen separate episodes of mixed error kinds, all while active.
    tx_role = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      err_ep(i % 5, 3);
      m_tec += 8;
      push_model($sformatf("ep%0d", i));
      sb_drain();
    end
    bt_err = 1'b1; tick(1);
    sb_push("ep16_cnt/tec", SEL_TEC, 128);
    sb_push("ep16_cnt/state", SEL_ST, 0);
    sb_drain();
    tick(1);
    m_tec = 128;
    push_model("ep16_state");
    sb_drain();
    bt_err = 1'b0; tick(2);

    bt_err = 1'b1; tick(20); bt_err = 1'b0; tick(2);
    m_tec = 136;
    push_model("long_err");
    sb_drain();

    err_ep(4, 3);
    push_model("psv_ack_only");
    sb_drain();
    err_ep(0, 3);
    m_tec = 144;
    push_model("psv_bit_err");
    sb_drain();

    bt_err = 1'b1; tx_success = 1'b1; tick(1); tx_success = 1'b0; tick(2);
    bt_err = 1'b0; tick(2);
    m_tec = 152;
    push_model("err_vs_txok");
    sb_drain();
    tx_ok();
    m_tec = 151;
    push_model("tx_ok");
    sb_drain();

    do_reset();
    tx_role = 1'b0;
    bt_err = 1'b1; dom_aft_flg = 1'b1; tick(1); dom_aft_flg = 1'b0; tick(1);
    bt_err = 1'b0; tick(2);
    m_rec = 9;
    push_model("rx_err_dom");
    sb_drain();
    for (int i = 0; i < 15; i++) begin
      dom_aft_flg = 1'b1; tick(1); dom_aft_flg = 1'b0; tick(1);
    end
    m_rec = 129;
    push_model("rec129");
    sb_drain();
    for (int i = 0; i < 16; i++) begin
      dom_aft_flg = 1'b1; tick(1); dom_aft_flg = 1'b0; tick(1);
    end
    tick(1);
    m_rec = 255;
    push_model("rec_clip");
    sb_drain();
    rx_success = 1'b1; tick(1); rx_success = 1'b0;
    sb_push("reload/rec", SEL_REC, 120);
    sb_push("reload/state_lag", SEL_ST, 1);
    sb_drain();
    tick(1);
    m_rec = 120;
    push_model("reload");
    sb_drain();
    rx_ok();
    m_rec = 119;
    push_model("rx_dec");
    sb_drain();

    do_reset();
    tx_role = 1'b1;
    tx_ok();
    rx_ok();
    push_model("zero_floor");
    sb_drain();
    for (int i = 0; i < 31; i++) err_ep(i % 4, 2);
    m_tec = 248;
    push_model("tec248");
    sb_drain();
    bt_err = 1'b1; tick(1);
    sb_push("boff_cnt/tec", SEL_TEC, 256);
    sb_push("boff_cnt/boff_lag", SEL_BOFF, 0);
    sb_drain();
    tick(1);
    m_tec = 256; m_boff = 1'b1;
    push_model("bus_off");
    sb_drain();
    bt_err = 1'b0; tick(2);
    err_ep(1, 2);
    tx_ok();
    tx_role = 1'b0;
    err_ep(2, 2);
    dom_aft_flg = 1'b1; tick(1); dom_aft_flg = 1'b0; tick(1);
    rx_ok();
    tx_role = 1'b1;
    push_model("boff_ignore");
    sb_drain();

    n_rcvry = 0;
    for (int s = 0; s < 128; s++) begin
      if (s == 4) begin
        for (int b = 0; b < 5; b++) send_bit(1'b1);
        send_bit(1'b0);
      end
      for (int b = 0; b < 10; b++) send_bit(1'b1);
      if (s == 127) begin
        sb_push("pre_rcvry/boff", SEL_BOFF, 1);
        sb_push("pre_rcvry/tec", SEL_TEC, 256);
        sb_drain();
        check_val("pre_rcvry/count", n_rcvry, 0);
        smp_pls = 1'b1; tick(1); smp_pls = 1'b0;
        m_tec = 0; m_rec = 0; m_boff = 1'b0;
        push_model("rcvry");
        sb_push("rcvry/pulse", SEL_RCV, 1);
        sb_drain();
        tick(1);
        sb_push("rcvry/pulse_end", SEL_RCV, 0);
        sb_drain();
      end else begin
        send_bit(1'b1);
      end
    end
    tick(4);
    check_val("rcvry/count", n_rcvry, 1);

    do_reset();
    to_bus_off();
    push_model("boff2");
    sb_drain();
    for (int i = 0; i < 40 * 11; i++) send_bit(1'b1);
    g_rst = 1'b1; #1;
    m_tec = 0; m_rec = 0; m_boff = 1'b0;
    push_model("rst_mid_rcvry");
    sb_push("rst_mid_rcvry/rcvry", SEL_RCV, 0);
    sb_drain();
    tick(1);
    g_rst = 1'b0;
    tick(3);
    push_model("after_rst");
    sb_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
